// File: rtl/polymul_seq11_if.sv
// Operand/product handshake bundle for polymul_seq11: valid/ready in, valid/ready out, busy.
interface polymul_seq11_if #(parameter int LIMBS = 4);
   localparam int W = 11 * LIMBS;
   localparam int P = 22 * LIMBS - 1;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [P-1:0] d;
   logic         busy;

   modport master (output in_valid, a, b, out_ready,
                   input  in_ready, out_valid, d, busy);
   modport slave  (input  in_valid, a, b, out_ready,
                   output in_ready, out_valid, d, busy);
endinterface

// File: rtl/polymul_seq11.sv
// Sequential GF(2)[x] multiplier: one 11x11 limb pair per cycle through ks11, XOR-accumulated; LIMBS^2 cycles, held in OUT under backpressure.
// Define POLYMUL_PIPE_EN to register the ks11 product before accumulation (adds a DRAIN cycle).
module ks11 (
   input  logic [10:0] x_i,
   input  logic [10:0] y_i,
   output logic [20:0] p_o
);
   function automatic logic [10:0] clmul6(input logic [5:0] u, input logic [5:0] v);
      logic [10:0] r;
      r = '0;
      for (int k = 0; k < 6; k++)
         if (v[k]) r = r ^ (11'(u) << k);
      return r;
   endfunction

   logic [5:0]  xl, yl, xh, yh;
   logic [10:0] lo, hi, mid;

   // One Karatsuba level: split 6 low / 5 high coefficients, middle term from (xl+xh)(yl+yh).
   always_comb begin
      xl  = x_i[5:0];
      yl  = y_i[5:0];
      xh  = {1'b0, x_i[10:6]};
      yh  = {1'b0, y_i[10:6]};
      lo  = clmul6(xl, yl);
      hi  = clmul6(xh, yh);
      mid = clmul6(xl ^ xh, yl ^ yh) ^ lo ^ hi;
      p_o = 21'(lo) ^ (21'(mid) << 6) ^ (21'(hi) << 12);
   end
endmodule

module polymul_seq11 #(
   parameter int LIMBS = 4
) (
   input logic            clk,
   input logic            rst,
   polymul_seq11_if.slave bus
);
   localparam int W = 11 * LIMBS;
   localparam int P = 22 * LIMBS - 1;
   localparam logic [2:0] LAST = 3'(LIMBS - 1);

   typedef enum logic [1:0] {IDLE, MUL, DRAIN, OUT} state_t;

   state_t       state_q, state_d;
   logic [W-1:0] ra_q, ra_d, rb_q, rb_d;
   logic [P-1:0] acc_q, acc_d;
   logic [2:0]   i_q, i_d, j_q, j_d;
   logic [3:0]   off;
   logic [20:0]  prod;

`ifdef POLYMUL_PIPE_EN
   logic [20:0]  prod_q, prod_d;
   logic [3:0]   off_q, off_d;
   logic         pvld_q, pvld_d;
`endif

   assign off = {1'b0, i_q} + {1'b0, j_q};

   ks11 u_ks11 (
      .x_i (11'(ra_q >> (11 * i_q))),
      .y_i (11'(rb_q >> (11 * j_q))),
      .p_o (prod)
   );

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      acc_d   = acc_q;
      i_d     = i_q;
      j_d     = j_q;
`ifdef POLYMUL_PIPE_EN
      prod_d  = prod;
      off_d   = off;
      pvld_d  = (state_q == MUL);
      // The product registered last cycle lands now, at the offset it was computed for.
      if (pvld_q) acc_d = acc_q ^ (P'(prod_q) << (11 * off_q));
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               ra_d    = bus.a;
               rb_d    = bus.b;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = MUL;
            end
         end
         MUL: begin
`ifndef POLYMUL_PIPE_EN
            acc_d = acc_q ^ (P'(prod) << (11 * off));
`endif
            if (j_q == LAST) begin
               j_d = '0;
               if (i_q == LAST) begin
`ifdef POLYMUL_PIPE_EN
                  state_d = DRAIN;
`else
                  state_d = OUT;
`endif
               end else begin
                  i_d = i_q + 3'd1;
               end
            end else begin
               j_d = j_q + 3'd1;
            end
         end
         DRAIN:   state_d = OUT;
         OUT:     if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
`ifdef POLYMUL_PIPE_EN
         prod_q  <= '0;
         off_q   <= '0;
         pvld_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         j_q     <= j_d;
`ifdef POLYMUL_PIPE_EN
         prod_q  <= prod_d;
         off_q   <= off_d;
         pvld_q  <= pvld_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == OUT);
   assign bus.busy      = (state_q != IDLE);
   assign bus.d         = acc_q;
endmodule
